bcd_display_scan: RTL and testbench
===================================

Name: bcd_display_scan

Overview:
- Display stage directly downstream of the clock-domain-crossing buffer. Consumes 16-bit words on the clk_2 side, together with the current module code and clock-programme value.
- Converts each accepted word to 5 BCD digits with a sequential shift-add-3 engine.
- Time-multiplexes 8 common-anode seven-segment digits (value, module glyph, programme number).

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit; range 2..2^20.
- DIGITS, 8: number of anodes; fixed at 8, present for readability only.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- data_in  in  16  unsigned word from buffer.
- data_valid  in  1  single-cycle strobe; data_in is valid this cycle.
- modulo  in  2  module code: 2'b10 fibonacci, 2'b01 timer, others idle.
- prog  in  3  registered clock-programme value, 0..7.
- busy  out  1  BCD conversion in progress.
- an  out  8  anode enables, active-low, one-hot.
- dec_ddp  out  8  segments, active-low: [7]=a … [1]=g, [0]=dp.

Behaviour:
- Reset values: an=8'hFF, dec_ddp=8'hFF, busy=0, displayed BCD=00000, scan index=0, divider=0, pending flag=0.
- Conversion FSM states: S_IDLE, S_SHIFT, S_DONE.
  - S_IDLE: on data_valid, load the 16-bit shift register from data_in, clear the 20-bit BCD field and iteration counter, then go to S_SHIFT. busy=1 from the next cycle.
  - S_SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left 1. After 16 iterations go to S_DONE.
  - S_DONE: copy the BCD field to the display register, then go to S_IDLE. busy=0 in S_IDLE only.
  - Latency: result is visible on the display register 18 cycles after the data_valid cycle.
- data_valid while busy:
  - Word is captured into a one-deep pending register; the pending flag is set.
  - A later strobe overwrites the pending word; newest wins, older words are dropped.
  - S_DONE with the pending flag set goes straight to a new S_SHIFT load from the pending register and clears the flag.
  - data_valid in the same cycle as S_DONE goes to the pending register, not a direct load.
- Maximum value 65535 → digits 6,5,5,3,5. No overflow path exists.
- Scan logic:
  - Divider counts 0..REFRESH_DIV-1. On wrap, the scan index increments, 7→0.
  - an = ~(8'b1 << index), registered. an and dec_ddp change on the same clk edge.
- Digit map:
  - idx0..4 = BCD digit 0 (units) .. digit 4.
  - idx5 = blank (8'hFF).
  - idx6 = module glyph: 'F' for 2'b10, 't' for 2'b01, '-' (g only) for others.
  - idx7 = prog as a decimal digit.
  - dp is always off (bit0=1).
- modulo and prog are sampled combinationally at each digit output update; no latching.
- Reset mid-conversion aborts immediately. Any pending word is discarded and the display returns to 00000.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: BCD digits above the most-significant non-zero digit show blank (8'hFF). Digit 0 is always shown, so value 0 shows a single '0'.
- Undefined: all five digits are always shown, zeros included.

Decomposition:
- Package bcd_display_pkg holds:
  - 7-seg constants: SEG_0..SEG_9 (active-low {a..g,dp}; SEG_0=8'h03, SEG_1=8'h9F), SEG_F, SEG_T, SEG_DASH, SEG_BLANK=8'hFF.
  - Module codes MOD_FIB=2'b10, MOD_TIM=2'b01.
  - FSM state encodings.
- Sub-module bin2bcd_seq: the conversion FSM plus the pending register. Ports: clk, rst, start, bin_in[15:0], busy, done, bcd_out[19:0].
- Top of this block: scan divider, digit mux, segment decode.

Test Plan:
- Reset: rst high mid-scan → an=8'hFF, dec_ddp=8'hFF, busy=0. After release, first tick gives an=8'hFE, dec_ddp=8'h03.
- Conversion: data_valid with data_in=16'd12345 → busy high for 17 cycles. Display register =20'h12345 at cycle 18. idx0 shows '5', idx4 shows '1' (8'h9F).
- Max value: data_in=16'hFFFF → BCD 20'h65535 with no corruption of digit 4.
- Back-to-back: strobes at t, t+3 (100), t+5 (200) → 100 is dropped. Final display 00200 after two conversions. busy stays high continuously until done.
- Glyphs and scan: modulo=2'b10, prog=3'd5, REFRESH_DIV=4 → anode pattern cycles FE,FD,…,7F every 4 cycles. idx6='F', idx7='5', idx5=8'hFF.
- LEADING_ZERO_BLANK_EN defined: data_in=16'd42 → idx2..4 blank, idx1='4', idx0='2'. data_in=0 → only idx0='0'.

Source files
------------

// File: rtl/bcd_display_pkg.sv
// Shared constants for the BCD display scan block: active-low seven-segment
// patterns {a,b,c,d,e,f,g,dp}, module codes and conversion FSM states.
package bcd_display_pkg;

  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_F     = 8'h71;
  localparam logic [7:0] SEG_T     = 8'hE1;
  localparam logic [7:0] SEG_DASH  = 8'hFD;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] MOD_FIB = 2'b10;
  localparam logic [1:0] MOD_TIM = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } b2b_state_e;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
// Word/strobe input and display output bundle between the CDC buffer side
// (master) and the display scan stage (slave).
interface bcd_display_scan_if;
  logic [15:0] data_in;
  logic        data_valid;
  logic [1:0]  modulo;
  logic [2:0]  prog;
  logic        busy;
  logic [7:0]  an;
  logic [7:0]  dec_ddp;

  modport master (
    output data_in, data_valid, modulo, prog,
    input  busy, an, dec_ddp
  );

  modport slave (
    input  data_in, data_valid, modulo, prog,
    output busy, an, dec_ddp
  );
endinterface

// File: rtl/bcd_display_scan_bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (shift-add-3) with a
// one-deep newest-wins pending word for strobes that arrive while busy.
//   state   | meaning
//   S_IDLE  | waiting for a word (direct strobe or leftover pending word)
//   S_SHIFT | 16 adjust-and-shift iterations
//   S_DONE  | bcd_out valid for one cycle; chain into pending word if any
module bin2bcd_seq
  import bcd_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd_out
);

  b2b_state_e  state_q, state_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic [3:0]  iter_q, iter_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] pend_q, pend_d;
  logic [19:0] bcd_adj;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d      = bin_in;
          bcd_d      = '0;
          iter_d     = '0;
          pend_vld_d = 1'b0;
          state_d    = S_SHIFT;
        end else if (pend_vld_q) begin
          bin_d      = pend_q;
          bcd_d      = '0;
          iter_d     = '0;
          pend_vld_d = 1'b0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[18:0], bin_q, 1'b0};
        iter_d         = iter_q + 4'd1;
        if (iter_q == 4'd15) state_d = S_DONE;
        if (start) begin
          pend_d     = bin_in;
          pend_vld_d = 1'b1;
        end
      end
      S_DONE: begin
        // a strobe landing here always goes to pending, even when we chain
        if (pend_vld_q) begin
          bin_d      = pend_q;
          bcd_d      = '0;
          iter_d     = '0;
          pend_vld_d = 1'b0;
          state_d    = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
        if (start) begin
          pend_d     = bin_in;
          pend_vld_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign bcd_out = bcd_q;

endmodule

// File: rtl/bcd_display_scan.sv
// Display stage: BCD conversion of incoming words, refresh divider, digit mux
// and segment decode for 8 common-anode digits. Optional LEADING_ZERO_BLANK_EN.
module bcd_display_scan
  import bcd_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DIGITS      = 8
)
(
  input logic              clk,
  input logic              rst,
  bcd_display_scan_if.slave disp_if
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic             conv_busy, conv_done;
  logic [19:0]      conv_bcd;
  logic [19:0]      disp_q, disp_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       dig;

  bin2bcd_seq u_b2b (
    .clk     (clk),
    .rst     (rst),
    .start   (disp_if.data_valid),
    .bin_in  (disp_if.data_in),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd_out (conv_bcd)
  );

  always_comb begin
    disp_d = conv_done ? conv_bcd : disp_q;
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    idx_d  = (div_q == DIV_LAST) ? idx_q + 1'b1 : idx_q;
    an_d   = ~(8'(1) << idx_q);
  end

`ifdef LEADING_ZERO_BLANK_EN
  // lz[i]: digit i lies above the most-significant non-zero digit
  logic [7:0] lz;
  always_comb begin
    lz = 8'b1110_0000;
    for (int i = 4; i >= 1; i--) begin
      lz[i] = lz[i+1] && (disp_q[4*i +: 4] == 4'd0);
    end
  end
`endif

  always_comb begin
    seg_d = SEG_BLANK;
    dig   = 4'(disp_q >> {idx_q, 2'b00});
    case (idx_q)
      3'd5: seg_d = SEG_BLANK;
      3'd6: begin
        case (disp_if.modulo)
          MOD_FIB: seg_d = SEG_F;
          MOD_TIM: seg_d = SEG_T;
          default: seg_d = SEG_DASH;
        endcase
      end
      3'd7: seg_d = seg_digit({1'b0, disp_if.prog});
      default: begin
`ifdef LEADING_ZERO_BLANK_EN
        seg_d = lz[idx_q] ? SEG_BLANK : seg_digit(dig);
`else
        seg_d = seg_digit(dig);
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q <= '0;
      div_q  <= '0;
      idx_q  <= '0;
      an_q   <= 8'hFF;
      seg_q  <= 8'hFF;
    end else begin
      disp_q <= disp_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign disp_if.busy    = conv_busy;
  assign disp_if.an      = an_q;
  assign disp_if.dec_ddp = seg_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed self-checking bench for bcd_display_scan with a short refresh
// divider; expectations follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_bcd_display_scan;

  localparam int RDIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  bcd_display_scan_if dif ();

  bcd_display_scan #(.REFRESH_DIV(RDIV), .DIGITS(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .disp_if (dif)
  );

  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'h03;
`endif

  // Sample dec_ddp while the anode for digit idx is lit; x on timeout.
  task automatic wait_digit(input int idx, output logic [7:0] seg);
    logic [7:0] want;
    want = ~(8'(1) << idx);
    seg  = 8'hxx;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (dif.an === want) begin
        seg = dif.dec_ddp;
        break;
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    @(negedge clk);
    dif.data_in    = w;
    dif.data_valid = 1'b1;
    @(negedge clk);
    dif.data_valid = 1'b0;
  endtask

  task automatic count_busy(output int cyc);
    cyc = 0;
    for (int k = 0; k < 200; k++) begin
      if (dif.busy !== 1'b1) break;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (dif.an !== 8'hFF) $display("FAIL rst_an got %h want ff", dif.an); else n_pass++;
    n_checks++; if (dif.dec_ddp !== 8'hFF) $display("FAIL rst_seg got %h want ff", dif.dec_ddp); else n_pass++;
    n_checks++; if (dif.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", dif.busy); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (dif.an !== 8'hFE) $display("FAIL first_an got %h want fe", dif.an); else n_pass++;
    n_checks++; if (dif.dec_ddp !== 8'h03) $display("FAIL first_seg got %h want 03", dif.dec_ddp); else n_pass++;
    repeat (13) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (dif.an !== 8'hFF) $display("FAIL midscan_rst_an got %h want ff", dif.an); else n_pass++;
    n_checks++; if (dif.dec_ddp !== 8'hFF) $display("FAIL midscan_rst_seg got %h want ff", dif.dec_ddp); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_conversion();
    logic [7:0] exp_seg [5];
    logic [7:0] s;
    int cyc;
    exp_seg = '{8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F};
    send_word(16'd12345);
    count_busy(cyc);
    n_checks++; if (cyc != 17) $display("FAIL conv_busy_cycles got %0d want 17", cyc); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      wait_digit(i, s);
      n_checks++; if (s !== exp_seg[i]) $display("FAIL conv_digit%0d got %h want %h", i, s, exp_seg[i]); else n_pass++;
    end
  endtask

  task automatic test_max();
    logic [7:0] exp_seg [5];
    logic [7:0] s;
    int cyc;
    exp_seg = '{8'h49, 8'h0D, 8'h49, 8'h49, 8'h41};
    send_word(16'hFFFF);
    count_busy(cyc);
    n_checks++; if (cyc != 17) $display("FAIL max_busy_cycles got %0d want 17", cyc); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      wait_digit(i, s);
      n_checks++; if (s !== exp_seg[i]) $display("FAIL max_digit%0d got %h want %h", i, s, exp_seg[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] s;
    int cyc;
    send_word(16'd12345);
    repeat (3) @(negedge clk);
    send_word(16'd999);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (dif.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", dif.busy); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (dif.busy !== 1'b0) cyc++;
    end
    n_checks++; if (cyc != 0) $display("FAIL abort_pending_dropped busy_cycles %0d want 0", cyc); else n_pass++;
    wait_digit(0, s);
    n_checks++; if (s !== 8'h03) $display("FAIL abort_digit0 got %h want 03", s); else n_pass++;
    wait_digit(3, s);
    n_checks++; if (s !== LZ) $display("FAIL abort_digit3 got %h want %h", s, LZ); else n_pass++;
    wait_digit(4, s);
    n_checks++; if (s !== LZ) $display("FAIL abort_digit4 got %h want %h", s, LZ); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seg [5];
    logic [7:0] s;
    int cyc;
    exp_seg = '{8'h03, 8'h03, 8'h25, LZ, LZ};
    @(negedge clk);
    dif.data_in    = 16'd777;
    dif.data_valid = 1'b1;
    cyc = 0;
    for (int c = 1; c < 120; c++) begin
      @(negedge clk);
      dif.data_valid = (c == 3 || c == 5);
      dif.data_in    = (c == 3) ? 16'd100 : 16'd200;
      if (dif.busy !== 1'b1) break;
      cyc++;
    end
    dif.data_valid = 1'b0;
    n_checks++; if (cyc != 34) $display("FAIL b2b_busy_cycles got %0d want 34", cyc); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      wait_digit(i, s);
      n_checks++; if (s !== exp_seg[i]) $display("FAIL b2b_digit%0d got %h want %h", i, s, exp_seg[i]); else n_pass++;
    end
  endtask

  task automatic test_glyphs_scan();
    logic [7:0] s;
    logic [7:0] want;
    bit found;
    dif.modulo = 2'b10;
    dif.prog   = 3'd5;
    wait_digit(6, s);
    n_checks++; if (s !== 8'h71) $display("FAIL glyph_fib got %h want 71", s); else n_pass++;
    wait_digit(7, s);
    n_checks++; if (s !== 8'h49) $display("FAIL prog5 got %h want 49", s); else n_pass++;
    wait_digit(5, s);
    n_checks++; if (s !== 8'hFF) $display("FAIL idx5_blank got %h want ff", s); else n_pass++;
    @(negedge clk);
    dif.modulo = 2'b01;
    dif.prog   = 3'd7;
    wait_digit(6, s);
    n_checks++; if (s !== 8'hE1) $display("FAIL glyph_tim got %h want e1", s); else n_pass++;
    wait_digit(7, s);
    n_checks++; if (s !== 8'h1F) $display("FAIL prog7 got %h want 1f", s); else n_pass++;
    @(negedge clk);
    dif.modulo = 2'b00;
    dif.prog   = 3'd0;
    wait_digit(6, s);
    n_checks++; if (s !== 8'hFD) $display("FAIL glyph_idle00 got %h want fd", s); else n_pass++;
    wait_digit(7, s);
    n_checks++; if (s !== 8'h03) $display("FAIL prog0 got %h want 03", s); else n_pass++;
    @(negedge clk);
    dif.modulo = 2'b11;
    wait_digit(6, s);
    n_checks++; if (s !== 8'hFD) $display("FAIL glyph_idle11 got %h want fd", s); else n_pass++;

    found = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (dif.an !== 8'hFE) begin found = 1'b1; break; end
    end
    if (found) begin
      found = 1'b0;
      for (int k = 0; k < 64; k++) begin
        @(negedge clk);
        if (dif.an === 8'hFE) begin found = 1'b1; break; end
      end
    end
    n_checks++; if (!found) $display("FAIL scan_sync got timeout want an=fe"); else n_pass++;
    for (int k = 0; k < 8 * RDIV + 4; k++) begin
      want = ~(8'(1) << ((k / RDIV) % 8));
      n_checks++; if (dif.an !== want) $display("FAIL scan_an cycle %0d got %h want %h", k, dif.an, want); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_leading_zero();
    logic [7:0] exp_seg [5];
    logic [7:0] s;
    int cyc;
    exp_seg = '{8'h25, 8'h99, LZ, LZ, LZ};
    send_word(16'd42);
    count_busy(cyc);
    n_checks++; if (cyc != 17) $display("FAIL lz42_busy_cycles got %0d want 17", cyc); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      wait_digit(i, s);
      n_checks++; if (s !== exp_seg[i]) $display("FAIL lz42_digit%0d got %h want %h", i, s, exp_seg[i]); else n_pass++;
    end
    exp_seg = '{8'h03, LZ, LZ, LZ, LZ};
    send_word(16'd0);
    count_busy(cyc);
    for (int i = 0; i < 5; i++) begin
      wait_digit(i, s);
      n_checks++; if (s !== exp_seg[i]) $display("FAIL lz0_digit%0d got %h want %h", i, s, exp_seg[i]); else n_pass++;
    end
  endtask

  initial begin
    dif.data_in    = 16'd0;
    dif.data_valid = 1'b0;
    dif.modulo     = 2'b00;
    dif.prog       = 3'd0;
    test_reset();
    test_conversion();
    test_max();
    test_reset_abort();
    test_back_to_back();
    test_glyphs_scan();
    test_leading_zero();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
